param_seq_detector: RTL

- Parametrised Mealy serial sequence detector; successor to the fixed-pattern 1100 detector.
- Runtime-loadable pattern of SEQ_LEN bits, overlap/non-overlap mode, enable gating and a saturating match counter.
- Sits on a 1-bit serial input stream; op flags a match combinationally in the cycle the final pattern bit is present on ip.

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/seq_det_next.sv | 45 ++++
 rtl/param_seq_detector.sv | 52 +++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared limits, default reset pattern and state-width helper for the sequence detector
package seq_det_pkg;
    localparam int SEQ_LEN_MAX = 16;
    localparam logic [SEQ_LEN_MAX-1:0] PATTERN_RST_DEF = 16'b1100;
    function automatic int state_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_det_next.sv
// seq_det_next: combinational KMP-style prefix search giving the match flag and next prefix state
module seq_det_next import seq_det_pkg::*; #(
    parameter int SEQ_LEN = 4,
    localparam int STATE_W = state_w(SEQ_LEN)
) (
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic [STATE_W-1:0] state,
    input  logic               ip,
    input  logic               overlap,
    output logic               hit,
    output logic [STATE_W-1:0] next_state
);
    logic [SEQ_LEN-1:0] pat_rx;
    logic [SEQ_LEN-1:0] seen;
    logic [SEQ_LEN-1:0] window;
    logic               ok;
    int                 idx;
    assign hit = (state == STATE_W'(SEQ_LEN - 1)) && (ip == pattern[0]);
    // pattern in receive order: pat_rx[0] is the first bit on the wire
    always_comb begin
        for (int k = 0; k < SEQ_LEN; k++) pat_rx[k] = pattern[SEQ_LEN-1-k];
    end
    // consumed input as implied by the state: matched prefix followed by the current bit
    always_comb begin
        seen = '0;
        for (int k = 0; k < SEQ_LEN; k++)
            seen[k] = (k < int'(state)) ? pat_rx[k] : ((k == int'(state)) ? ip : 1'b0);
    end
    // longest proper prefix that is a suffix of seen; capping j below SEQ_LEN makes a full
    // match fall back to the pattern's own border, which is exactly the overlap restart point
    always_comb begin
        next_state = '0;
        ok = 1'b0;
        window = '0;
        idx = 0;
        for (int j = 1; j < SEQ_LEN; j++) begin
            idx = int'(state) + 1 - j;
            window = seen >> idx;
            ok = (j <= int'(state) + 1);
            for (int i = 0; i < j; i++) ok = ok && (window[i] == pat_rx[i]);
            if (ok) next_state = STATE_W'(j);
        end
        if (hit && !overlap) next_state = '0;
    end
endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector: loadable-pattern Mealy serial sequence detector with saturating match counter
module param_seq_detector import seq_det_pkg::*; #(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN_RST = SEQ_LEN'(PATTERN_RST_DEF),
    parameter int                 CNT_W       = 8,
    localparam int                STATE_W     = state_w(SEQ_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               ip,
    input  logic               overlap,
    input  logic               load,
    input  logic [SEQ_LEN-1:0] pattern_in,
    input  logic               clr_cnt,
    output logic               op,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   match_count
);
    logic [SEQ_LEN-1:0] pattern;
    logic               hit;
    logic [STATE_W-1:0] next_state;
    if (SEQ_LEN < 2 || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_len
        $error("SEQ_LEN out of range");
    end
    seq_det_next #(.SEQ_LEN(SEQ_LEN)) u_next (
        .pattern    (pattern),
        .state      (state),
        .ip         (ip),
        .overlap    (overlap),
        .hit        (hit),
        .next_state (next_state)
    );
    assign op = reset && en && !load && hit;
    // pattern and prefix state: reset beats load, load beats a sampled bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern <= PATTERN_RST;
            state   <= '0;
        end else if (load) begin
            pattern <= pattern_in;
            state   <= '0;
        end else if (en) begin
            state   <= next_state;
        end
    end
    // match counter: clear beats increment, and it sticks at all-ones
    always_ff @(posedge clk) begin
        if (!reset || clr_cnt) match_count <= '0;
        else if (op && match_count != '1) match_count <= match_count + 1'b1;
    end
endmodule
